// File: rtl/spi_slave_driver.sv
// SPI mode-0 responder: receives one NUM_DATA_BITS word on MOSI and returns the
// preloaded miso_data word on MISO for each slave-select window.
module spi_slave_driver #(
   parameter bit SS_ACTIVE_LOW = 1'b1,
   parameter bit LSB_FIRST     = 1'b0,
   parameter int NUM_DATA_BITS = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     ss_in,
   input  logic                     sclk_in,
   input  logic                     mosi_in,
   output logic                     miso_out,
   output logic                     miso_oe,
   input  logic [NUM_DATA_BITS-1:0] miso_data,
   output logic [NUM_DATA_BITS-1:0] mosi_data,
   output logic                     mosi_new_data,
   output logic                     busy
);

   localparam int   CW     = $clog2(NUM_DATA_BITS + 1);
   localparam logic SS_IDL = SS_ACTIVE_LOW;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [SYNC_STAGES-1:0]   ss_sync_q, sclk_sync_q, mosi_sync_q;
   logic                     ss_hist_q, sclk_hist_q;
   logic                     ss_act, ss_act_prev, ss_on, ss_off;
   logic                     sclk_s, sclk_rise, sclk_fall, mosi_s;
   state_t                   state_q, state_d;
   logic [NUM_DATA_BITS-1:0] tx_q, tx_d, rx_q, rx_d, mdata_q, mdata_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     miso_q, miso_d, new_q, new_d;

   function automatic logic out_bit(input logic [NUM_DATA_BITS-1:0] w);
      return LSB_FIRST ? w[0] : w[NUM_DATA_BITS-1];
   endfunction

   function automatic logic [NUM_DATA_BITS-1:0] advance(input logic [NUM_DATA_BITS-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [NUM_DATA_BITS-1:0] shift_in(input logic [NUM_DATA_BITS-1:0] r,
                                                         input logic b);
      if (LSB_FIRST) return {b, r[NUM_DATA_BITS-1:1]};
      return {r[NUM_DATA_BITS-2:0], b};
   endfunction

   // Equal-depth synchronizers keep MOSI aligned with the SCLK edge that samples it.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         ss_sync_q   <= {SYNC_STAGES{SS_IDL}};
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_hist_q   <= SS_IDL;
         sclk_hist_q <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_in};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign ss_act      = ss_sync_q[SYNC_STAGES-1] ^ SS_ACTIVE_LOW;
   assign ss_act_prev = ss_hist_q ^ SS_ACTIVE_LOW;
   assign ss_on       = ss_act & ~ss_act_prev;
   assign ss_off      = ~ss_act & ss_act_prev;
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_hist_q;
   assign sclk_fall   = ~sclk_s & sclk_hist_q;
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      miso_d  = miso_q;
      mdata_d = mdata_q;
      new_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_on) begin
               tx_d    = miso_data;
               miso_d  = out_bit(miso_data);
               cnt_d   = '0;
               rx_d    = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // SS edges win over a coincident SCLK edge.
            if (ss_off) begin
               miso_d  = 1'b1;
               state_d = IDLE;
            end else if (sclk_rise) begin
               rx_d  = shift_in(rx_q, mosi_s);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(NUM_DATA_BITS - 1)) begin
                  mdata_d = rx_d;
                  new_d   = 1'b1;
                  state_d = DONE;
               end
            end else if (sclk_fall && cnt_q != '0) begin
               tx_d   = advance(tx_q);
               miso_d = out_bit(advance(tx_q));
            end
         end
         DONE: begin
            if (ss_off) begin
               miso_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b1;
         mdata_q <= '0;
         new_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         miso_q  <= miso_d;
         mdata_q <= mdata_d;
         new_q   <= new_d;
      end
   end

   assign miso_out      = miso_q;
   assign miso_oe       = (state_q != IDLE);
   assign busy          = (state_q != IDLE);
   assign mosi_data     = mdata_q;
   assign mosi_new_data = new_q;

endmodule

// File: tb/tb_spi_slave_driver.sv
// Bench for spi_slave_driver: a mode-0 master model drives two responders
// (MSB-first/active-low SS and LSB-first/active-high SS) sharing SCLK and MOSI.
`timescale 1ns/1ps
module tb_spi_slave_driver;

   localparam int HALF = 8;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        ss0 = 1'b1;
   logic        ss1 = 1'b0;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic [15:0] mdin0 = '0, mdin1 = '0;
   logic [15:0] mdo0, mdo1;
   logic        miso0, miso1, oe0, oe1, mnd0, mnd1, busy0, busy1;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] last_rx0 = '0;

   spi_slave_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b0), .NUM_DATA_BITS(16), .SYNC_STAGES(2)) dut0 (
      .sys_clk(sys_clk), .rst(rst), .ss_in(ss0), .sclk_in(sclk), .mosi_in(mosi),
      .miso_out(miso0), .miso_oe(oe0), .miso_data(mdin0), .mosi_data(mdo0),
      .mosi_new_data(mnd0), .busy(busy0));

   spi_slave_driver #(.SS_ACTIVE_LOW(1'b0), .LSB_FIRST(1'b1), .NUM_DATA_BITS(16), .SYNC_STAGES(2)) dut1 (
      .sys_clk(sys_clk), .rst(rst), .ss_in(ss1), .sclk_in(sclk), .mosi_in(mosi),
      .miso_out(miso1), .miso_oe(oe1), .miso_data(mdin1), .mosi_data(mdo1),
      .mosi_new_data(mnd1), .busy(busy1));

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic sel(input int inst, input bit on);
      if (inst == 0) ss0 = ~on;
      else ss1 = on;
   endtask

   // Scoreboard monitors: every strobe must match the oldest expected word.
   always @(negedge sys_clk) begin
      logic [15:0] e;
      if (mnd0) begin
         if (q0.size() == 0) begin
            n_total++;
            $display("FAIL dut0_unexpected_strobe: got strobe with 0x%0h required none", mdo0);
         end else begin
            e = q0.pop_front();
            chk("dut0_mosi_data", mdo0, e);
         end
      end
   end

   always @(negedge sys_clk) begin
      logic [15:0] e;
      if (mnd1) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL dut1_unexpected_strobe: got strobe with 0x%0h required none", mdo1);
         end else begin
            e = q1.pop_front();
            chk("dut1_mosi_data", mdo1, e);
         end
      end
   end

   // One SS window of nbits SCLK cycles; rst_at>=0 pulses reset before that bit.
   task automatic xfer(input int inst, input logic [31:0] data, input int nbits,
                       input logic [15:0] reply, input int rst_at);
      logic        lsb;
      logic        b[32];
      logic [15:0] exp_w, got_w;
      logic        m;
      lsb   = (inst == 1);
      exp_w = '0;
      got_w = '0;
      if (inst == 0) mdin0 = reply;
      else mdin1 = reply;
      wait_cyc(2);
      for (int i = 0; i < nbits; i++) b[i] = lsb ? data[i] : data[nbits-1-i];
      for (int k = 0; k < 16; k++) begin
         if (k < nbits) begin
            if (lsb) exp_w[k] = b[k];
            else exp_w[15-k] = b[k];
         end
      end
      if (nbits >= 16 && rst_at < 0) begin
         if (inst == 0) begin
            q0.push_back(exp_w);
            last_rx0 = exp_w;
         end else q1.push_back(exp_w);
      end
      sel(inst, 1'b1);
      for (int i = 0; i < nbits; i++) begin
         mosi = b[i];
         if (i == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_miso_out", miso0, 1'b1);
            chk("rst_miso_oe", oe0, 1'b0);
            chk("rst_busy", busy0, 1'b0);
            chk("rst_mosi_data", mdo0, 16'h0000);
            chk("rst_strobe", mnd0, 1'b0);
            last_rx0 = '0;
            sclk = 1'b0;
            sel(inst, 1'b0);
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(6);
            return;
         end
         wait_cyc(HALF);
         sclk = 1'b1;
         m = (inst == 0) ? miso0 : miso1;
         if (i < 16) begin
            if (lsb) got_w[i] = m;
            else got_w[15-i] = m;
         end
         if (i == 0) begin
            chk("busy_in_xfer", (inst == 0) ? busy0 : busy1, 1'b1);
            chk("oe_in_xfer", (inst == 0) ? oe0 : oe1, 1'b1);
            if (inst == 0) mdin0 = 16'($urandom);
            else mdin1 = 16'($urandom);
         end
         wait_cyc(HALF);
         sclk = 1'b0;
      end
      wait_cyc(HALF);
      sel(inst, 1'b0);
      if (nbits >= 16) begin
         chk("master_rx", got_w, reply);
      end else begin
         wait_cyc(5);
         chk("abort_oe", oe0, 1'b0);
         chk("abort_busy", busy0, 1'b0);
         chk("abort_miso_out", miso0, 1'b1);
         chk("abort_mosi_kept", mdo0, last_rx0);
      end
      wait_cyc(HALF);
   endtask

   initial begin
      logic seen;
      wait_cyc(3);
      chk("reset_miso_out", miso0, 1'b1);
      chk("reset_miso_oe", oe0, 1'b0);
      chk("reset_mosi_data", mdo0, 16'h0000);
      chk("reset_strobe", mnd0, 1'b0);
      chk("reset_busy", busy0, 1'b0);
      rst = 1'b0;
      wait_cyc(4);

      xfer(0, 32'h0CF7, 16, 16'h4AC5, -1);
      xfer(0, 32'h37E1, 16, 16'h16FB, -1);
      xfer(0, 32'h2FA0, 16, 16'h35D9, -1);
      xfer(1, 32'hA5C3, 16, 16'h1234, -1);

      xfer(0, 32'hFFFF, 5, 16'h5A5A, -1);
      xfer(0, 32'h0001, 16, 16'($urandom), -1);

      xfer(0, {12'h0, 20'($urandom)}, 20, 16'($urandom), -1);

      seen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         sclk = ~sclk;
         mosi = 1'($urandom);
         for (int c = 0; c < HALF; c++) begin
            @(negedge sys_clk);
            seen = seen | busy0 | oe0 | busy1 | oe1;
         end
      end
      chk("idle_noise_quiet", seen, 1'b0);

      xfer(0, 32'h1234, 16, 16'($urandom), 8);
      xfer(0, 32'hBEEF, 16, 16'($urandom), -1);

      for (int k = 0; k < 8; k++) xfer(0, 32'($urandom_range(0, 16'hFFFF)), 16, 16'($urandom), -1);
      for (int k = 0; k < 4; k++) xfer(1, 32'($urandom_range(0, 16'hFFFF)), 16, 16'($urandom), -1);

      wait_cyc(20);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      repeat (60000) @(posedge sys_clk);
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
